// File: rtl/ov7670_cam_gen_pkg.sv
// Shared types and constants for the OV7670 camera emulator.
// Holds the FSM encoding and the eight RGB565 colour-bar values.
package ov7670_cam_gen_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVback,
    StActive,
    StVfront
  } cam_state_e;

  localparam logic [15:0] BarWhite   = 16'hFFFF;
  localparam logic [15:0] BarYellow  = 16'hFFE0;
  localparam logic [15:0] BarCyan    = 16'h07FF;
  localparam logic [15:0] BarGreen   = 16'h07E0;
  localparam logic [15:0] BarMagenta = 16'hF81F;
  localparam logic [15:0] BarRed     = 16'hF800;
  localparam logic [15:0] BarBlue    = 16'h001F;
  localparam logic [15:0] BarBlack   = 16'h0000;

  function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
    logic [15:0] rgb;
    unique case (idx)
      3'd0: rgb = BarWhite;
      3'd1: rgb = BarYellow;
      3'd2: rgb = BarCyan;
      3'd3: rgb = BarGreen;
      3'd4: rgb = BarMagenta;
      3'd5: rgb = BarRed;
      3'd6: rgb = BarBlue;
      3'd7: rgb = BarBlack;
    endcase
    return rgb;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ov7670_cam_gen_if.sv
// Camera-side bus: frame/line syncs, pixel byte and frame-done pulse.
// master = emulated sensor, slave = capture path.
interface ov7670_cam_gen_if;
  logic       enable;
  logic       vsync;
  logic       href;
  logic [7:0] px_data;
  logic       frame_done;

  modport master (input enable, output vsync, href, px_data, frame_done);
  modport slave  (output enable, input vsync, href, px_data, frame_done);
endinterface

// File: rtl/ov7670_pattern_gen.sv
// Maps next-cycle (x, line, byte_sel) to a pixel byte.
// OV7670_CAM_GEN_COLORBAR_EN selects colour bars; otherwise an address ramp.
module ov7670_pattern_gen
  import ov7670_cam_gen_pkg::*;
#(
  parameter int unsigned BAR_W = 20
) (
  input  logic       pclk,
  input  logic       async_reset,
  input  logic [7:0] i_x,
  input  logic [7:0] i_line,
  input  logic       i_byte_sel,
  input  logic       i_line_start,
  input  logic       i_px_adv,
  output logic [7:0] o_byte
);

`ifdef OV7670_CAM_GEN_COLORBAR_EN
  localparam int unsigned BW = cnt_width(BAR_W);
  localparam logic [BW-1:0] BarLast = BW'(BAR_W - 1);

  logic [BW-1:0] r_bar_cnt, w_bar_cnt_d;
  logic [2:0]    r_bar_idx, w_bar_idx_d;
  logic [15:0]   w_rgb;
  logic          w_unused;

  assign w_unused = ^{i_x, i_line};

  always_comb begin
    w_bar_cnt_d = r_bar_cnt;
    w_bar_idx_d = r_bar_idx;
    if (i_line_start) begin
      w_bar_cnt_d = '0;
      w_bar_idx_d = '0;
    end else if (i_px_adv) begin
      if (r_bar_cnt == BarLast) begin
        w_bar_cnt_d = '0;
        w_bar_idx_d = r_bar_idx + 3'd1;
      end else begin
        w_bar_cnt_d = r_bar_cnt + BW'(1);
      end
    end
  end

  always_ff @(negedge pclk or posedge async_reset) begin
    if (async_reset) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else begin
      r_bar_cnt <= w_bar_cnt_d;
      r_bar_idx <= w_bar_idx_d;
    end
  end

  assign w_rgb  = bar_rgb(w_bar_idx_d);
  assign o_byte = i_byte_sel ? w_rgb[7:0] : w_rgb[15:8];
`else
  logic w_unused;

  assign w_unused = ^{pclk, async_reset, i_line_start, i_px_adv};
  assign o_byte   = i_byte_sel ? i_x : i_line;
`endif

endmodule

// File: rtl/ov7670_cam_gen.sv
// OV7670 sensor emulator: frame/line timing FSM driving vsync/href/px_data on falling pclk.
// Pattern selected by OV7670_CAM_GEN_COLORBAR_EN (colour bars) or its absence (ramp).
module ov7670_cam_gen
  import ov7670_cam_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE      = 160,
  parameter int unsigned V_ACTIVE      = 120,
  parameter int unsigned H_BLANK       = 144,
  parameter int unsigned VSYNC_LINES   = 3,
  parameter int unsigned V_BACK_LINES  = 17,
  parameter int unsigned V_FRONT_LINES = 10,
  parameter int unsigned BAR_W         = 20
) (
  input logic              pclk,
  input logic              async_reset,
  ov7670_cam_gen_if.master cam
);

  localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned M1 = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int unsigned M2 = (V_BACK_LINES > V_FRONT_LINES) ? V_BACK_LINES : V_FRONT_LINES;
  localparam int unsigned CW = cnt_width(LINE_LEN);
  localparam int unsigned LW = cnt_width((M1 > M2) ? M1 : M2);
  localparam int unsigned XW = cnt_width(H_ACTIVE);

  localparam logic [CW-1:0] CycLast   = CW'(LINE_LEN - 1);
  localparam logic [CW:0]   HrefLen   = (CW + 1)'(2 * H_ACTIVE);
  localparam logic [LW-1:0] VsyncLast = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VbackLast = LW'(V_BACK_LINES - 1);
  localparam logic [LW-1:0] ActLast   = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] VfrntLast = LW'(V_FRONT_LINES - 1);

  cam_state_e    r_state, w_state_d;
  logic [CW-1:0] r_cyc, w_cyc_d;
  logic [LW-1:0] r_line, w_line_d;
  logic [XW-1:0] r_x, w_x_d;
  logic          r_sel, w_sel_d;
  logic          r_vsync, r_href, r_frame_done;
  logic [7:0]    r_px_data;
  logic          w_href_d, w_line_end, w_px_adv, w_line_start;
  logic [7:0]    w_byte;

  assign w_line_end = (r_cyc == CycLast);

  always_comb begin
    w_state_d = r_state;
    w_cyc_d   = r_cyc;
    w_line_d  = r_line;
    if (r_state != StIdle) begin
      w_cyc_d = w_line_end ? '0 : r_cyc + CW'(1);
      if (w_line_end) w_line_d = r_line + LW'(1);
    end
    // Every phase change lands on a line boundary, so cyc_d is already 0 there.
    unique case (r_state)
      StIdle: begin
        if (cam.enable) w_state_d = StVsync;
      end
      StVsync: begin
        if (w_line_end && r_line == VsyncLast) begin
          w_state_d = StVback;
          w_line_d  = '0;
        end
      end
      StVback: begin
        if (w_line_end && r_line == VbackLast) begin
          w_state_d = StActive;
          w_line_d  = '0;
        end
      end
      StActive: begin
        if (w_line_end && r_line == ActLast) begin
          w_state_d = StVfront;
          w_line_d  = '0;
        end
      end
      StVfront: begin
        if (w_line_end && r_line == VfrntLast) begin
          w_state_d = cam.enable ? StVsync : StIdle;
          w_line_d  = '0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_href_d     = (w_state_d == StActive) && ({1'b0, w_cyc_d} < HrefLen);
    w_line_start = w_href_d && !r_href;
    w_px_adv     = w_href_d && r_href && r_sel;
    w_sel_d      = w_href_d && r_href && !r_sel;
    w_x_d        = '0;
    if (w_href_d) w_x_d = w_px_adv ? r_x + XW'(1) : r_x;
  end

  ov7670_pattern_gen #(
    .BAR_W (BAR_W)
  ) u_pattern (
    .pclk         (pclk),
    .async_reset  (async_reset),
    .i_x          (8'(w_x_d)),
    .i_line       (8'(w_line_d)),
    .i_byte_sel   (w_sel_d),
    .i_line_start (w_line_start),
    .i_px_adv     (w_px_adv),
    .o_byte       (w_byte)
  );

  always_ff @(negedge pclk or posedge async_reset) begin
    if (async_reset) begin
      r_state      <= StIdle;
      r_cyc        <= '0;
      r_line       <= '0;
      r_x          <= '0;
      r_sel        <= 1'b0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_px_data    <= 8'h00;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cyc        <= w_cyc_d;
      r_line       <= w_line_d;
      r_x          <= w_x_d;
      r_sel        <= w_sel_d;
      r_vsync      <= (w_state_d == StVsync);
      r_href       <= w_href_d;
      r_px_data    <= w_href_d ? w_byte : 8'h00;
      r_frame_done <= (w_state_d == StVfront) && (r_state != StVfront);
    end
  end

  assign cam.vsync      = r_vsync;
  assign cam.href       = r_href;
  assign cam.px_data    = r_px_data;
  assign cam.frame_done = r_frame_done;

endmodule
